// File: rtl/l3_gan_loader.sv
// Host-side loader for one l3_gan core: turns a header-framed word stream into the
// core's parameter/input buses, runs one inference and streams back out1..out4.
module l3_gan_loader #(
    parameter int DW      = 16,
    parameter int N_PARAM = 73,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DW-1:0]     m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              err,
    output logic              params_loaded,
    output logic [DW-1:0]     x1,
    output logic [DW-1:0]     x2,
    output logic [DW-1:0]     x3,
    output logic [DW-1:0]     x4,
    output logic [16*DW-1:0]  L1_w,
    output logic [4*DW-1:0]   L1_b,
    output logic [8*DW-1:0]   L2_w,
    output logic [2*DW-1:0]   L2_b,
    output logic [2*DW-1:0]   L3_w,
    output logic [DW-1:0]     L3_b,
    output logic [DW-1:0]     L4_w,
    output logic [DW-1:0]     L4_b,
    output logic [DW-1:0]     L5_w,
    output logic [DW-1:0]     L5_b,
    output logic [2*DW-1:0]   L6_w,
    output logic [2*DW-1:0]   L6_b,
    output logic [8*DW-1:0]   L7_w,
    output logic [4*DW-1:0]   L7_b,
    output logic [16*DW-1:0]  L8_w,
    output logic [4*DW-1:0]   L8_b,
    output logic              start,
    input  logic              done,
    input  logic [DW-1:0]     out1,
    input  logic [DW-1:0]     out2,
    input  logic [DW-1:0]     out3,
    input  logic [DW-1:0]     out4
);

    localparam int PW  = N_PARAM * DW;
    localparam int CW  = $clog2(N_PARAM);
    localparam int WCW = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0] HDR_P = DW'(16'hA501);
    localparam logic [DW-1:0] HDR_X = DW'(16'hA502);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_P = 3'd1;
    localparam logic [2:0] ST_LOAD_X = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_SEND   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [PW-1:0]  params_q, params_d;
    logic [4*DW-1:0] x_q, x_d;
    logic [4*DW-1:0] res_q, res_d;
    logic           loaded_q, loaded_d;
    logic           err_q, err_d;
    logic           accept;

    assign s_ready = rst && (state_q == ST_IDLE || state_q == ST_LOAD_P || state_q == ST_LOAD_X);
    assign accept  = s_valid && s_ready;

    // cnt_q is shared: parameter word index, x word index, and result word index in SEND
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        params_d = params_q;
        x_d      = x_q;
        res_d    = res_q;
        loaded_d = loaded_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (s_data == HDR_P) begin
                        state_d  = ST_LOAD_P;
                        loaded_d = 1'b0;
                    end else if (s_data == HDR_X) begin
                        state_d = ST_LOAD_X;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_P: begin
                if (accept) begin
                    params_d[int'(cnt_q)*DW +: DW] = s_data;
                    if (cnt_q == CW'(N_PARAM - 1)) begin
                        loaded_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD_X: begin
                if (accept) begin
                    x_d[int'(cnt_q[1:0])*DW +: DW] = s_data;
                    if (cnt_q == CW'(3)) begin
                        cnt_d = '0;
                        if (loaded_q) begin
                            state_d = ST_START;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    res_d   = {out4, out3, out2, out1};
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (m_ready) begin
                    if (cnt_q == CW'(3)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            params_q <= '0;
            x_q      <= '0;
            res_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            params_q <= params_d;
            x_q      <= x_d;
            res_q    <= res_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

    assign start         = (state_q == ST_START);
    assign m_valid       = (state_q == ST_SEND);
    assign m_data        = res_q[int'(cnt_q[1:0])*DW +: DW];
    assign err           = err_q;
    assign params_loaded = loaded_q;

    assign x1 = x_q[0*DW +: DW];
    assign x2 = x_q[1*DW +: DW];
    assign x3 = x_q[2*DW +: DW];
    assign x4 = x_q[3*DW +: DW];

    // Word offsets follow the flat load order L1_w, L1_b, L2_w, ... L8_b
    assign L1_w = params_q[0*DW  +: 16*DW];
    assign L1_b = params_q[16*DW +: 4*DW];
    assign L2_w = params_q[20*DW +: 8*DW];
    assign L2_b = params_q[28*DW +: 2*DW];
    assign L3_w = params_q[30*DW +: 2*DW];
    assign L3_b = params_q[32*DW +: DW];
    assign L4_w = params_q[33*DW +: DW];
    assign L4_b = params_q[34*DW +: DW];
    assign L5_w = params_q[35*DW +: DW];
    assign L5_b = params_q[36*DW +: DW];
    assign L6_w = params_q[37*DW +: 2*DW];
    assign L6_b = params_q[39*DW +: 2*DW];
    assign L7_w = params_q[41*DW +: 8*DW];
    assign L7_b = params_q[49*DW +: 4*DW];
    assign L8_w = params_q[53*DW +: 16*DW];
    assign L8_b = params_q[69*DW +: 4*DW];

endmodule

// File: tb/tb_l3_gan_loader.sv
// Directed-sequence bench for l3_gan_loader with random words, a behavioural
// core model, and a reference of the flat parameter order.
module tb_l3_gan_loader;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid, s_ready;
    logic [15:0] m_data;
    logic        m_valid, m_ready;
    logic        err, params_loaded;
    logic [15:0] x1, x2, x3, x4;
    logic [255:0] L1_w, L8_w;
    logic [63:0]  L1_b, L7_b, L8_b;
    logic [127:0] L2_w, L7_w;
    logic [31:0]  L2_b, L3_w, L6_w, L6_b;
    logic [15:0]  L3_b, L4_w, L4_b, L5_w, L5_b;
    logic        start, done;
    logic [15:0] out1, out2, out3, out4;

    int n_checks = 0;
    int n_errs   = 0;

    logic [15:0] exp_param [73];
    logic [15:0] exp_out [4];
    bit          exp_loaded = 1'b0;
    int          bus_words [16] = '{16, 4, 8, 2, 2, 1, 1, 1, 1, 1, 2, 2, 8, 4, 16, 4};

    l3_gan_loader #(.DW(16), .N_PARAM(73), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .err(err), .params_loaded(params_loaded),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .L1_w(L1_w), .L1_b(L1_b), .L2_w(L2_w), .L2_b(L2_b),
        .L3_w(L3_w), .L3_b(L3_b), .L4_w(L4_w), .L4_b(L4_b),
        .L5_w(L5_w), .L5_b(L5_b), .L6_w(L6_w), .L6_b(L6_b),
        .L7_w(L7_w), .L7_b(L7_b), .L8_w(L8_w), .L8_b(L8_b),
        .start(start), .done(done),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errs++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One word handshake, bounded so a stuck s_ready cannot hang the run
    task automatic applyStimulus(input logic [15:0] w);
        bit took = 1'b0;
        s_data  = w;
        s_valid = 1'b1;
        for (int i = 0; i < 20 && !took; i++) begin
            took = s_ready;
            cyc();
        end
        s_valid = 1'b0;
        if (!took) checkOutput("s_ready_stuck", 256'(0), 256'(1));
    endtask

    function automatic logic [255:0] exp_bus(input int k);
        int off = 0;
        logic [255:0] r = '0;
        for (int i = 0; i < k; i++) off += bus_words[i];
        for (int j = 0; j < bus_words[k]; j++) r[16*j +: 16] = exp_param[off+j];
        return r;
    endfunction

    function automatic logic [255:0] dut_bus(input int k);
        case (k)
            0:  return 256'(L1_w);
            1:  return 256'(L1_b);
            2:  return 256'(L2_w);
            3:  return 256'(L2_b);
            4:  return 256'(L3_w);
            5:  return 256'(L3_b);
            6:  return 256'(L4_w);
            7:  return 256'(L4_b);
            8:  return 256'(L5_w);
            9:  return 256'(L5_b);
            10: return 256'(L6_w);
            11: return 256'(L6_b);
            12: return 256'(L7_w);
            13: return 256'(L7_b);
            14: return 256'(L8_w);
            default: return 256'(L8_b);
        endcase
    endfunction

    task automatic check_all_buses(input string tag);
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("%s_bus%0d", tag, k), dut_bus(k), exp_bus(k));
    endtask

    task automatic load_params(input bit directed);
        applyStimulus(16'hA501);
        checkOutput("loaded_clear_on_entry", 256'(params_loaded), 256'(0));
        for (int i = 0; i < 73; i++) begin
            exp_param[i] = 16'($urandom);
            if (directed && i == 0)  exp_param[i] = 16'd6;
            if (directed && i == 15) exp_param[i] = 16'hFFF8;
            if (directed && i == 72) exp_param[i] = 16'hFFF6;
            if (i == 72) checkOutput("loaded_before_last", 256'(params_loaded), 256'(0));
            applyStimulus(exp_param[i]);
        end
        exp_loaded = 1'b1;
        checkOutput("loaded_set", 256'(params_loaded), 256'(1));
        checkOutput("s_ready_after_load", 256'(s_ready), 256'(1));
        check_all_buses("load");
    endtask

    // Full inference: header, four x words, then the core model and result collection
    task automatic infer(input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] xc,
                         input logic [15:0] xd, input bit toggle, input bit hang);
        logic [15:0] xw [4];
        logic [15:0] got [$];
        logic [15:0] held = '0;
        bit stalled = 1'b0;
        bit mv_seen = 1'b0;
        int c;
        int lat;
        xw = '{xa, xb, xc, xd};
        applyStimulus(16'hA502);
        for (int i = 0; i < 4; i++) applyStimulus(xw[i]);
        checkOutput("x1", 256'(x1), 256'(xw[0]));
        checkOutput("x2", 256'(x2), 256'(xw[1]));
        checkOutput("x3", 256'(x3), 256'(xw[2]));
        checkOutput("x4", 256'(x4), 256'(xw[3]));
        checkOutput("start_after_x4", 256'(start), 256'(exp_loaded));
        if (!exp_loaded) begin
            checkOutput("err_unloaded", 256'(err), 256'(1));
            for (int i = 0; i < 4; i++) begin
                cyc();
                checkOutput("start_never", 256'(start), 256'(0));
            end
            checkOutput("err_one_cycle", 256'(err), 256'(0));
            return;
        end
        checkOutput("s_ready_in_start", 256'(s_ready), 256'(0));
        cyc();
        checkOutput("start_one_cycle", 256'(start), 256'(0));
        if (hang) begin
            for (c = 1; c <= 40; c++) begin
                if (err) break;
                if (m_valid) mv_seen = 1'b1;
                cyc();
            end
            checkOutput("watchdog_cycle", 256'(c), 256'(TMO + 1));
            checkOutput("watchdog_no_mvalid", 256'({mv_seen, m_valid}), 256'(0));
            checkOutput("watchdog_idle", 256'(s_ready), 256'(1));
            cyc();
            checkOutput("watchdog_err_pulse", 256'(err), 256'(0));
            return;
        end
        lat = $urandom_range(0, 10);
        repeat (lat) cyc();
        for (int i = 0; i < 4; i++) exp_out[i] = 16'($urandom);
        out1 = exp_out[0]; out2 = exp_out[1]; out3 = exp_out[2]; out4 = exp_out[3];
        done = 1'b1;
        cyc();
        done = 1'b0;
        out1 = ~exp_out[0]; out2 = ~exp_out[1]; out3 = ~exp_out[2]; out4 = ~exp_out[3];
        for (int k = 0; k < 60 && got.size() < 4; k++) begin
            m_ready = toggle ? (k % 2 == 0) : 1'b1;
            if (stalled) begin
                checkOutput("stall_valid", 256'(m_valid), 256'(1));
                checkOutput("stall_data", 256'(m_data), 256'(held));
            end
            if (m_valid && m_ready) got.push_back(m_data);
            stalled = m_valid && !m_ready;
            held    = m_data;
            cyc();
        end
        m_ready = 1'b0;
        checkOutput("result_count", 256'(got.size()), 256'(4));
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("result%0d", i), 256'((i < got.size()) ? got[i] : 16'hxxxx),
                        256'(exp_out[i]));
        checkOutput("mvalid_after_send", 256'(m_valid), 256'(0));
        checkOutput("err_after_send", 256'(err), 256'(0));
        checkOutput("idle_after_send", 256'(s_ready), 256'(1));
    endtask

    initial begin
        rst = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0; done = 1'b0;
        out1 = '0; out2 = '0; out3 = '0; out4 = '0;
        for (int i = 0; i < 73; i++) exp_param[i] = '0;
        cyc();
        cyc();
        checkOutput("rst_s_ready", 256'(s_ready), 256'(0));
        checkOutput("rst_outs", 256'({start, err, m_valid, params_loaded}), 256'(0));
        rst = 1'b1;

        $display("[TB] reset in the middle of a parameter load");
        applyStimulus(16'hA501);
        for (int i = 0; i < 30; i++) applyStimulus(16'($urandom | 1));
        rst = 1'b0;
        cyc();
        cyc();
        check_all_buses("midrst");
        checkOutput("midrst_x", 256'({x1, x2, x3, x4}), 256'(0));
        checkOutput("midrst_ctrl", 256'({start, err, m_valid, s_ready, params_loaded}), 256'(0));
        rst = 1'b1;
        #1;
        checkOutput("idle_after_rst", 256'(s_ready), 256'(1));

        $display("[TB] error cases");
        applyStimulus(16'h1234);
        checkOutput("bad_header_err", 256'(err), 256'(1));
        cyc();
        checkOutput("bad_header_pulse", 256'(err), 256'(0));
        checkOutput("bad_header_idle", 256'({s_ready, params_loaded}), 256'(2));
        infer(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, 1'b0);

        $display("[TB] directed load and inference");
        load_params(1'b1);
        checkOutput("L1_w_lsb", 256'(L1_w[15:0]), 256'(16'd6));
        checkOutput("L1_w_msb", 256'(L1_w[255:240]), 256'(16'hFFF8));
        checkOutput("L8_b_msb", 256'(L8_b[63:48]), 256'(16'hFFF6));
        infer(16'd0, 16'd1, 16'd1, 16'd0, 1'b0, 1'b0);
        check_all_buses("after_infer");

        $display("[TB] backpressure");
        infer(16'd0, 16'd1, 16'd1, 16'd0, 1'b1, 1'b0);

        $display("[TB] watchdog");
        infer(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b1);
        infer(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);

        $display("[TB] random reload and inferences");
        load_params(1'b0);
        for (int r = 0; r < 4; r++)
            infer(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), r[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
